// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared sizing helpers for the pipeline-stage buffer.
//   ptr_width(depth) - pointer width for a circular buffer of 'depth' entries.
//                      Never returns 0, so a DEPTH=1 buffer still has a legal
//                      1-bit pointer; that pointer is held at 0.
//   cnt_width(depth) - width of an occupancy counter that can hold 0..depth.
package pipe_stage_buf_pkg;

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// pipe_buf_mem: DEPTH x DW storage array with one write port and one
// asynchronous read port. The array is not reset. It is kept separate so the
// control logic stays the same if the array is later mapped to LUTRAM.
//   clk    in  clock; the write happens on the rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out combinational read data, mem[raddr]
module pipe_buf_mem #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised valid/ready buffer between two pipeline stages,
// built as a circular buffer of DEPTH entries with a synchronous flush.
//   clk        in  clock; all state updates on the rising edge
//   rst_n      in  asynchronous active-low reset
//   flush      in  discard all entries at the next edge
//   in_valid   in  upstream holds a valid payload
//   in_ready   out buffer accepts this cycle
//   in_data    in  upstream payload (DW bits)
//   out_valid  out head entry valid
//   out_ready  in  downstream accepts the head entry
//   out_data   out head entry payload (DW bits)
//   count      out current occupancy, 0..DEPTH
// PASS_READY=1 lets a pop free a slot in the same cycle, so in_ready may depend
// on out_ready. PASS_READY=0 makes in_ready depend on occupancy only.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned DW         = 64,
  parameter int unsigned DEPTH      = 2,
  parameter bit          PASS_READY = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  // DEPTH is a power of two, so the natural binary wrap is modulo DEPTH.
  // A single-entry buffer keeps both pointers at 0.
  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign in_ready  = PASS_READY ? (~full | out_ready) : ~full;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A same-cycle push is dropped; a same-cycle pop already completed downstream.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full with push and pop together, wr_ptr equals rd_ptr: the head is
  // read out combinationally this cycle and overwritten at the edge.
  pipe_buf_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: four instances (D2/P0, D4/P0, D1/P1, D1/P0) share
// one clock and reset. Every accepted push queues its payload; a monitor pops
// and compares whenever an instance presents a handshake on its output.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       iv  [4];
  logic       ir  [4];
  logic       ov  [4];
  logic       orr [4];
  logic       fl  [4];
  logic [7:0] id  [4];
  logic [7:0] od  [4];
  logic [2:0] cnt [4];
  int         pops [4];

  logic [1:0] cnt_a;
  logic [2:0] cnt_b;
  logic       cnt_c;
  logic       cnt_d;

  assign cnt[0] = 3'(cnt_a);
  assign cnt[1] = cnt_b;
  assign cnt[2] = 3'(cnt_c);
  assign cnt[3] = 3'(cnt_d);

  logic [7:0] q [4][$];
  logic       hold   [4];
  logic [7:0] hold_d [4];
  logic [7:0] exp_v;

  pipe_stage_buf #(.DW(8), .DEPTH(2), .PASS_READY(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .count(cnt_a)
  );
  pipe_stage_buf #(.DW(8), .DEPTH(4), .PASS_READY(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .count(cnt_b)
  );
  pipe_stage_buf #(.DW(8), .DEPTH(1), .PASS_READY(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .count(cnt_c)
  );
  pipe_stage_buf #(.DW(8), .DEPTH(1), .PASS_READY(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(id[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od[3]), .count(cnt_d)
  );

  function automatic int depth_of(int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit pass_of(int k);
    return (k == 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act, input logic [31:0] exp);
    bad++;
    $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor and property checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (32'(cnt[k]) > 32'(depth_of(k)))
          flag($sformatf("dut%0d_count_le_depth", k), 32'(cnt[k]), 32'(depth_of(k)));
        if (!pass_of(k) && iv[k] && ir[k] && 32'(cnt[k]) == 32'(depth_of(k)))
          flag($sformatf("dut%0d_push_when_full", k), 32'(ir[k]), 32'd0);
        if (hold[k] && od[k] !== hold_d[k])
          flag($sformatf("dut%0d_stall_stable", k), 32'(od[k]), 32'(hold_d[k]));
        if (ov[k] && orr[k]) begin
          pops[k]++;
          if (q[k].size() == 0) begin
            flag($sformatf("dut%0d_unexpected_pop", k), 32'(od[k]), 32'hFFFF_FFFF);
          end else begin
            exp_v = q[k].pop_front();
            chk($sformatf("dut%0d_out_data", k), 32'(od[k]), 32'(exp_v));
          end
        end
        if (fl[k]) q[k].delete();
        else if (iv[k] && ir[k]) q[k].push_back(id[k]);
        hold[k]   = ov[k] && !orr[k] && !fl[k];
        hold_d[k] = od[k];
      end
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      hold[k] = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; fl[k] = 1'b0; id[k] = 8'h00; pops[k] = 0;
      hold[k] = 1'b0; hold_d[k] = 8'h00;
    end
    #12 rst_n = 1'b1;
    step(1);

    // Reset state of every instance.
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dut%0d_rst_count", k), 32'(cnt[k]), 32'd0);
      chk($sformatf("dut%0d_rst_out_valid", k), 32'(ov[k]), 32'd0);
      chk($sformatf("dut%0d_rst_in_ready", k), 32'(ir[k]), 32'd1);
    end

    // Asynchronous reset mid-stream on the DEPTH=4 instance.
    iv[1] = 1'b1; id[1] = 8'h01; step(1);
    id[1] = 8'h02; step(1);
    iv[1] = 1'b0;
    chk("b_pre_reset_count", 32'(cnt[1]), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("b_async_rst_out_valid", 32'(ov[1]), 32'd0);
    chk("b_async_rst_count", 32'(cnt[1]), 32'd0);
    chk("b_async_rst_in_ready", 32'(ir[1]), 32'd1);
    #3 rst_n = 1'b1;
    step(1);
    iv[1] = 1'b1; id[1] = 8'h0A; step(1);
    id[1] = 8'h0B; step(1);
    iv[1] = 1'b0;
    chk("b_post_reset_head", 32'(od[1]), 32'h0A);
    chk("b_post_reset_count", 32'(cnt[1]), 32'd2);
    orr[1] = 1'b1; step(2);
    orr[1] = 1'b0;
    chk("b_post_reset_drained", 32'(cnt[1]), 32'd0);

    // Sustained throughput on DEPTH=2, PASS_READY=0.
    pops[0] = 0;
    iv[0] = 1'b1; orr[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id[0] = 8'(i);
      step(1);
      chk($sformatf("a_pops_at_%0d", i), 32'(pops[0]), 32'(i));
      chk($sformatf("a_count_at_%0d", i), 32'(cnt[0]), 32'd1);
      chk($sformatf("a_in_ready_at_%0d", i), 32'(ir[0]), 32'd1);
    end
    iv[0] = 1'b0;
    step(1);
    chk("a_total_pops", 32'(pops[0]), 32'd16);
    chk("a_final_count", 32'(cnt[0]), 32'd0);
    orr[0] = 1'b0;

    // Backpressure and pointer wrap on DEPTH=4.
    iv[1] = 1'b1;
    id[1] = 8'h11; step(1);
    id[1] = 8'h22; step(1);
    id[1] = 8'h33; step(1);
    id[1] = 8'h44; step(1);
    id[1] = 8'h66; step(1);  // offered while full, must be refused
    iv[1] = 1'b0;
    chk("b_full_count", 32'(cnt[1]), 32'd4);
    chk("b_full_in_ready", 32'(ir[1]), 32'd0);
    chk("b_full_head", 32'(od[1]), 32'h11);
    step(1);
    chk("b_stall_head", 32'(od[1]), 32'h11);
    orr[1] = 1'b1; step(4);
    chk("b_drain_count", 32'(cnt[1]), 32'd0);
    iv[1] = 1'b1; id[1] = 8'h55; step(1);
    iv[1] = 1'b0;
    chk("b_after_wrap_head", 32'(od[1]), 32'h55);
    step(1);
    chk("b_after_wrap_count", 32'(cnt[1]), 32'd0);
    orr[1] = 1'b0;

    // DEPTH=1, PASS_READY=1: full with simultaneous push and pop.
    iv[2] = 1'b1; id[2] = 8'h07; step(1);
    chk("c_full_count", 32'(cnt[2]), 32'd1);
    chk("c_full_in_ready", 32'(ir[2]), 32'd0);
    id[2] = 8'h08; orr[2] = 1'b1;
    #1;
    chk("c_pass_in_ready", 32'(ir[2]), 32'd1);
    step(1);
    chk("c_swap_count", 32'(cnt[2]), 32'd1);
    chk("c_swap_head", 32'(od[2]), 32'h08);
    iv[2] = 1'b0; step(1);
    chk("c_drain_count", 32'(cnt[2]), 32'd0);
    orr[2] = 1'b0;

    // Flush with concurrent push and pop on DEPTH=4.
    iv[1] = 1'b1;
    id[1] = 8'h31; step(1);
    id[1] = 8'h32; step(1);
    id[1] = 8'h33; step(1);
    chk("b_pre_flush_count", 32'(cnt[1]), 32'd3);
    fl[1] = 1'b1; id[1] = 8'h99; orr[1] = 1'b1;
    step(1);
    fl[1] = 1'b0; iv[1] = 1'b0;
    chk("b_flush_count", 32'(cnt[1]), 32'd0);
    chk("b_flush_out_valid", 32'(ov[1]), 32'd0);
    step(3);
    chk("b_flush_stays_empty", 32'(ov[1]), 32'd0);
    orr[1] = 1'b0;

    // DEPTH=1, PASS_READY=0: one transfer every two cycles.
    pops[3] = 0;
    iv[3] = 1'b1; orr[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("d_in_ready_at_%0d", i), 32'(ir[3]), (i % 2 == 0) ? 32'd1 : 32'd0);
      id[3] = 8'(8'h40 + i);
      step(1);
    end
    iv[3] = 1'b0;
    chk("d_total_pops", 32'(pops[3]), 32'd4);
    chk("d_final_count", 32'(cnt[3]), 32'd0);
    orr[3] = 1'b0;
    step(2);

    for (int k = 0; k < 4; k++)
      chk($sformatf("dut%0d_scoreboard_empty", k), 32'(q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic parametrised pipeline-stage buffer for valid/ready handshakes between adjacent stages (IF->ID, ID->EX, ...).
- Successor to the single-entry stage register, which has fixed IF/ID fields and no flush.
- Adds configurable payload width, configurable depth (circular buffer), synchronous flush, an occupancy output and a selectable ready mode.
- In registered-ready mode, in_ready never depends combinationally on out_ready.

Parameters:
- DW, 64: payload width in bits; the IF/ID use packs {pc, inst}.
- DEPTH, 2: number of entries; legal values 1, 2, 4, 8.
- PASS_READY, 0: 1 = in_ready may depend on out_ready (pop frees a slot in the same cycle); 0 = in_ready depends on occupancy only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries; takes effect at the next edge.
- in_valid  in  1  upstream holds valid payload.
- in_ready  out  1  buffer can accept this cycle.
- in_data  in  DW  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DW  head entry payload.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, wr_ptr=0, rd_ptr=0, out_valid=0, in_ready=1.
  - Storage array is not reset.
  - out_data is don't-care while out_valid=0.
- Definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - full = (count==DEPTH).
  - empty = (count==0).
- out_valid = ~empty.
- out_data = mem[rd_ptr], a combinational read of a registered entry. There is no input->output bypass, so latency is exactly 1 cycle from push to out_valid.
- in_ready:
  - PASS_READY=0: in_ready = ~full.
  - PASS_READY=1: in_ready = ~full | out_ready.
  - Never depends on flush or on in_valid.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH (DEPTH=1: pointer logic is constant 0).
- On push: mem[wr_ptr] <= in_data, then wr_ptr advances.
- On pop: rd_ptr advances.
- count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Simultaneous push and pop:
  - When full (PASS_READY=1 only): head leaves, new entry is written to the freed slot; count stays DEPTH.
  - When count=1: the new entry becomes head next cycle.
- Flush has priority over push and pop.
  - At the edge where flush=1: count<=0, wr_ptr<=0, rd_ptr<=0.
  - A push handshake in the same cycle is dropped; upstream sees it as accepted and the data is discarded.
  - A pop in the same cycle still completes on the downstream side, since out_valid/out_data were valid that cycle.
- Throughput: one transfer per cycle sustained if DEPTH>=2, or if DEPTH=1 with PASS_READY=1. DEPTH=1 with PASS_READY=0 is limited to one transfer every 2 cycles.
- Stall: when out_ready=0, the head entry and its out_data stay stable until popped or flushed.
- Reset asserted mid-operation: all content lost immediately. The first push after deassertion lands in entry 0.
- Assertions in the bench (synthesis-off):
  - no push when full and PASS_READY=0;
  - count never exceeds DEPTH;
  - out_data stable while out_valid & ~out_ready.

Decomposition:
- No shared package typedef is needed.
- Stage payload structs (if_id_t, id_ex_t) and their widths go in the existing pipeline package; instantiations use $bits(...) for DW.
- Everything is inline: occupancy/pointer control plus the storage array.
- One natural sub-module, pipe_buf_mem: a DEPTH x DW write-port / async-read array. It keeps the control FSM reusable if the array later maps to LUTRAM.

Test Plan:
- Reset: hold rst_n=0 mid-stream with count=2 -> out_valid=0, count=0, in_ready=1 without a clock edge; after release, push 0xA then 0xB -> out_data=0xA first.
- Throughput (DEPTH=2, PASS_READY=0): in_valid=1 and out_ready=1 for 16 cycles with data 0..15 -> 16 pops in order 0..15, one per cycle after 1-cycle latency, count stays <=1.
- Backpressure (DEPTH=4): out_ready=0, push 0x11..0x44 -> count=4, in_ready=0, out_data=0x11 stable; raise out_ready -> pops 0x11,0x22,0x33,0x44 in order, pointers wrap, then push 0x55 pops correctly.
- Full with simultaneous push/pop (DEPTH=1, PASS_READY=1): entry 0x7 held, in_valid=1 with 0x8, out_ready=1 -> 0x7 popped, 0x8 accepted in the same cycle, count stays 1.
- Flush: count=3, flush=1 together with push 0x99 and pop -> next cycle count=0, out_valid=0; 0x99 never appears on the output.
- DEPTH=1, PASS_READY=0: continuous in_valid and out_ready -> in_ready toggles 1,0,1,0 and exactly one transfer every 2 cycles.
